// File: rtl/m_p88_loader.sv
// P88 program loader: parses C8 data / CA entry records from the ioctl download stream,
// writes payload into RAM and plants a FAR JMP at the ROM boot vector.
module m_p88_loader #(
    parameter int          ADDR_W    = 20,
    parameter int          MEM_W     = 8,
    parameter int          WR_CYCLES = 2,
    parameter int unsigned VEC_BASE  = 0
) (
    input  logic                 clk_sys,
    input  logic                 resetL,
    input  logic                 ioctl_download,
    input  logic                 ioctl_wr,
    input  logic [7:0]           ioctl_dout,
    output logic                 ioctl_wait,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [MEM_W-1:0]     mem_din,
    output logic [MEM_W/8-1:0]   mem_be,
    output logic                 mem_we,
    output logic                 mem_sel,
    output logic                 hold_reset,
    output logic                 done,
    output logic                 err
);

    localparam int BE_W = MEM_W / 8;

    // state  | meaning
    // IDLE   | no download in progress
    // CMD    | waiting for a record command byte
    // HDR    | collecting C8 (8 bytes) or CA (4 bytes) header
    // DATA   | waiting for the next C8 payload byte
    // WRITE  | RAM write pulse plus one recovery cycle
    // VEC    | writing the 5-byte FAR JMP into ROM
    // ERR    | bad command seen; swallow bytes until download ends
    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_HDR, S_DATA, S_WRITE, S_VEC, S_ERR
    } state_t;

    state_t              state_q;
    logic                dl_q;
    logic                wait_q, we_q, sel_q, hold_q, done_q, err_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [MEM_W-1:0]    din_q;
    logic [BE_W-1:0]     be_q;
    logic [3:0]          tmr_q;
    logic [2:0]          hcnt_q;
    logic [2:0]          vidx_q;
    logic                is_ca_q;
    logic [15:0]         seg_q, off_q, len_q;

    logic                accept, rise, fall;
    logic [ADDR_W-1:0]   rec_addr;
    logic [15:0]         len_next;

    function automatic logic [BE_W-1:0] lane_be(input logic lsb);
        return (BE_W == 1) ? '1 : BE_W'(1) << lsb;
    endfunction

    function automatic logic [MEM_W-1:0] rep(input logic [7:0] b);
        return {BE_W{b}};
    endfunction

    function automatic logic [7:0] vec_byte(input logic [2:0] k, input logic [15:0] seg,
                                            input logic [15:0] off);
        case (k)
            3'd0:    return 8'hEA;
            3'd1:    return off[7:0];
            3'd2:    return off[15:8];
            3'd3:    return seg[7:0];
            default: return seg[15:8];
        endcase
    endfunction

    always_comb begin
        accept   = ioctl_wr & ~wait_q;
        rise     = ioctl_download & ~dl_q;
        fall     = ~ioctl_download & dl_q;
        rec_addr = ADDR_W'({4'h0, seg_q, 4'h0} + {8'h0, off_q});
        len_next = {ioctl_dout, len_q[7:0]};
    end

    always_ff @(posedge clk_sys or negedge resetL) begin
        if (!resetL) begin
            state_q <= S_IDLE;
            dl_q    <= 1'b0;
            wait_q  <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= 1'b0;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            be_q    <= '0;
            tmr_q   <= '0;
            hcnt_q  <= '0;
            vidx_q  <= '0;
            is_ca_q <= 1'b0;
            seg_q   <= '0;
            off_q   <= '0;
            len_q   <= '0;
        end else begin
            dl_q   <= ioctl_download;
            done_q <= 1'b0;
            if (fall) begin
                // Any write in flight is dropped on the floor.
                state_q <= S_IDLE;
                we_q    <= 1'b0;
                wait_q  <= 1'b0;
                sel_q   <= 1'b0;
                hold_q  <= 1'b0;
                done_q  <= ~err_q;
            end else if (rise) begin
                state_q <= S_CMD;
                hold_q  <= 1'b1;
                err_q   <= 1'b0;
                we_q    <= 1'b0;
                wait_q  <= 1'b0;
                sel_q   <= 1'b0;
            end else begin
                case (state_q)
                    S_CMD: if (accept) begin
                        hcnt_q <= '0;
                        if (ioctl_dout == 8'hC8) begin
                            is_ca_q <= 1'b0;
                            state_q <= S_HDR;
                        end else if (ioctl_dout == 8'hCA) begin
                            is_ca_q <= 1'b1;
                            state_q <= S_HDR;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= S_ERR;
                        end
                    end
                    S_HDR: if (accept) begin
                        hcnt_q <= hcnt_q + 3'd1;
                        case (hcnt_q)
                            3'd0:    seg_q[7:0]  <= ioctl_dout;
                            3'd1:    seg_q[15:8] <= ioctl_dout;
                            3'd2:    off_q[7:0]  <= ioctl_dout;
                            3'd3:    off_q[15:8] <= ioctl_dout;
                            3'd6:    len_q[7:0]  <= ioctl_dout;
                            3'd7:    len_q       <= len_next;
                            default: ;
                        endcase
                        if (is_ca_q && hcnt_q == 3'd3) begin
                            state_q <= S_VEC;
                            wait_q  <= 1'b1;
                            sel_q   <= 1'b1;
                            addr_q  <= ADDR_W'(VEC_BASE);
                            din_q   <= rep(8'hEA);
                            be_q    <= lane_be(VEC_BASE[0]);
                            we_q    <= 1'b1;
                            tmr_q   <= 4'(WR_CYCLES - 1);
                            vidx_q  <= '0;
                        end else if (!is_ca_q && hcnt_q == 3'd7) begin
                            addr_q  <= rec_addr;
                            state_q <= (len_next == 16'h0) ? S_CMD : S_DATA;
                        end
                    end
                    S_DATA: if (accept) begin
                        din_q   <= rep(ioctl_dout);
                        be_q    <= lane_be(addr_q[0]);
                        we_q    <= 1'b1;
                        wait_q  <= 1'b1;
                        tmr_q   <= 4'(WR_CYCLES - 1);
                        state_q <= S_WRITE;
                    end
                    S_WRITE: begin
                        if (tmr_q != 4'h0) begin
                            tmr_q <= tmr_q - 4'h1;
                        end else if (we_q) begin
                            we_q <= 1'b0;
                        end else begin
                            addr_q  <= addr_q + 1'b1;
                            len_q   <= len_q - 16'h1;
                            wait_q  <= 1'b0;
                            state_q <= (len_q == 16'h1) ? S_CMD : S_DATA;
                        end
                    end
                    S_VEC: begin
                        if (tmr_q != 4'h0) begin
                            tmr_q <= tmr_q - 4'h1;
                        end else if (we_q) begin
                            we_q <= 1'b0;
                        end else if (vidx_q == 3'd4) begin
                            state_q <= S_CMD;
                            wait_q  <= 1'b0;
                            sel_q   <= 1'b0;
                        end else begin
                            // Next vector byte starts right after the one-cycle gap.
                            vidx_q <= vidx_q + 3'd1;
                            addr_q <= addr_q + 1'b1;
                            din_q  <= rep(vec_byte(vidx_q + 3'd1, seg_q, off_q));
                            be_q   <= lane_be(~addr_q[0]);
                            we_q   <= 1'b1;
                            tmr_q  <= 4'(WR_CYCLES - 1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign ioctl_wait = wait_q;
    assign mem_addr   = addr_q;
    assign mem_din    = din_q;
    assign mem_be     = be_q;
    assign mem_we     = we_q;
    assign mem_sel    = sel_q;
    assign hold_reset = hold_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule
